sal_cmd_scheduler: RTL and testbench



---
 rtl/sal_sched_pkg.sv | 44 ++++
 rtl/sal_rr_arbiter.sv | 37 +++
 rtl/sal_cmd_scheduler.sv | 133 +++++++++++++
 tb/tb_sal_cmd_scheduler.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sal_sched_pkg.sv
// Shared definitions for the DDR2 command scheduler.
// Holds the command encoding, the timer width and small helpers for
// command eligibility and timer update.
package sal_sched_pkg;

  typedef enum logic [2:0] {
    NOP = 3'd0,
    ACT = 3'd1,
    RD  = 3'd2,
    WR  = 3'd3,
    PRE = 3'd4
  } cmd_t;

  localparam int TMR_W = 4;

  // A command may issue only when the shared timers that guard it have expired.
  // Codes outside ACT/RD/WR/PRE are never eligible.
  function automatic logic cmd_eligible(input logic [2:0] code,
                                        input logic       rrd_zero,
                                        input logic       col_zero,
                                        input logic       wtr_zero,
                                        input logic       rtw_zero);
    logic ok;
    ok = 1'b0;
    case (code)
      ACT:     ok = rrd_zero;
      RD:      ok = col_zero && wtr_zero;
      WR:      ok = col_zero && rtw_zero;
      PRE:     ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Saturating down-counter step; a load takes priority over the decrement.
  function automatic logic [TMR_W-1:0] tmr_next(input logic             load,
                                                input logic [TMR_W-1:0] load_val,
                                                input logic [TMR_W-1:0] cur);
    if (load) return load_val;
    if (cur != '0) return cur - 1'b1;
    return '0;
  endfunction

endpackage

// File: rtl/sal_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   eligible  - request vector, one bit per requester
//   rr_ptr    - index with highest priority this cycle
//   grant     - one-hot winner (all zero when nothing is eligible)
//   grant_idx - index of the winner (0 when nothing is eligible)
module sal_rr_arbiter #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  always_comb begin
    int  j;
    logic found;
    // NOTE: every variable gets a default before the loop so no path can
    // leave a value unassigned and infer a latch.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    // Search upward from rr_ptr with wrap; the first eligible index wins.
    for (int i = 0; i < N; i++) begin
      j = (int'(rr_ptr) + i) % N;
      if (!found && eligible[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/sal_cmd_scheduler.sv
// DDR2 command-bus scheduler shared by the per-bank controllers.
// Picks at most one eligible bank request per cycle (round-robin), enforces
// the inter-bank timings tRRD/tCCD/tWTR/tRTW and holds off all issue while a
// refresh is requested.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   bk_req_valid/cmd/addr - per-bank request (cmd bank i at [3i+2:3i])
//   bk_grant              - one-hot, same-cycle acceptance of a bank request
//   ref_req / ref_ack     - refresh handshake; ack is registered
//   cmd_valid/cmd/cmd_ba/cmd_addr - registered command to the PHY side
module sal_cmd_scheduler
  import sal_sched_pkg::*;
#(
  parameter int NUM_BK = 8,
  parameter int ADDR_W = 14,
  parameter int T_RRD  = 2,
  parameter int T_CCD  = 2,
  parameter int T_WTR  = 3,
  parameter int T_RTW  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_BK-1:0]         bk_req_valid,
  input  logic [NUM_BK*3-1:0]       bk_req_cmd,
  input  logic [NUM_BK*ADDR_W-1:0]  bk_req_addr,
  output logic [NUM_BK-1:0]         bk_grant,
  input  logic                      ref_req,
  output logic                      ref_ack,
  output logic                      cmd_valid,
  output logic [2:0]                cmd,
  output logic [$clog2(NUM_BK)-1:0] cmd_ba,
  output logic [ADDR_W-1:0]         cmd_addr
);

  localparam int BA_W = $clog2(NUM_BK);
  // Loading T-1 makes the earliest follow-up command land exactly T cycles later.
  localparam logic [TMR_W-1:0] RRD_LD = TMR_W'(T_RRD - 1);
  localparam logic [TMR_W-1:0] CCD_LD = TMR_W'(T_CCD - 1);
  localparam logic [TMR_W-1:0] WTR_LD = TMR_W'(T_WTR - 1);
  localparam logic [TMR_W-1:0] RTW_LD = TMR_W'(T_RTW - 1);

  logic [TMR_W-1:0]  rrd_cnt, col_cnt, wtr_cnt, rtw_cnt;
  logic [TMR_W-1:0]  rrd_nxt, col_nxt, wtr_nxt, rtw_nxt;
  logic [BA_W-1:0]   rr_ptr;
  logic [NUM_BK-1:0] eligible;
  logic [NUM_BK-1:0] arb_grant;
  logic [BA_W-1:0]   arb_idx;
  logic              grant_any;
  logic [2:0]        win_cmd;
  logic [ADDR_W-1:0] win_addr;

  // Refresh and reset both suppress every grant in the same cycle.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_BK; i++) begin
      eligible[i] = bk_req_valid[i] && !ref_req && !rst &&
                    cmd_eligible(bk_req_cmd[3*i +: 3], rrd_cnt == '0,
                                 col_cnt == '0, wtr_cnt == '0, rtw_cnt == '0);
    end
  end

  sal_rr_arbiter #(.N(NUM_BK)) u_arb (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  assign bk_grant  = arb_grant;
  assign grant_any = |arb_grant;

  // The grant is one-hot, so an OR-mux picks the winner's command and address.
  always_comb begin
    win_cmd  = '0;
    win_addr = '0;
    for (int i = 0; i < NUM_BK; i++) begin
      if (arb_grant[i]) begin
        win_cmd  = bk_req_cmd[3*i +: 3];
        win_addr = bk_req_addr[ADDR_W*i +: ADDR_W];
      end
    end
  end

  always_comb begin
    rrd_nxt = tmr_next(grant_any && win_cmd == ACT, RRD_LD, rrd_cnt);
    col_nxt = tmr_next(grant_any && (win_cmd == RD || win_cmd == WR), CCD_LD, col_cnt);
    wtr_nxt = tmr_next(grant_any && win_cmd == WR, WTR_LD, wtr_cnt);
    rtw_nxt = tmr_next(grant_any && win_cmd == RD, RTW_LD, rtw_cnt);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      rrd_cnt   <= '0;
      col_cnt   <= '0;
      wtr_cnt   <= '0;
      rtw_cnt   <= '0;
      rr_ptr    <= '0;
      ref_ack   <= 1'b0;
      cmd_valid <= 1'b0;
      cmd       <= NOP;
      cmd_ba    <= '0;
      cmd_addr  <= '0;
    end else begin
      rrd_cnt <= rrd_nxt;
      col_cnt <= col_nxt;
      wtr_cnt <= wtr_nxt;
      rtw_cnt <= rtw_nxt;
      if (grant_any) begin
        rr_ptr   <= (arb_idx == BA_W'(NUM_BK - 1)) ? '0 : arb_idx + 1'b1;
        cmd_ba   <= arb_idx;
        cmd_addr <= win_addr;
      end
      cmd_valid <= grant_any;
      cmd       <= grant_any ? win_cmd : NOP;
      // Ack means: bus idle in the ack cycle (no command granted just before)
      // and every shared timer has expired.
      ref_ack   <= ref_req && !grant_any &&
                   rrd_nxt == '0 && col_nxt == '0 && wtr_nxt == '0 && rtw_nxt == '0;
    end
  end

  // A valid request must carry a real command code.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_BK; i++) begin
        if (bk_req_valid[i]) assert (bk_req_cmd[3*i +: 3] inside {ACT, RD, WR, PRE});
      end
    end
  end

endmodule

// File: tb/tb_sal_cmd_scheduler.sv
// Directed, table-driven bench for sal_cmd_scheduler (default parameters).
// Each table entry is one clock cycle: inputs are driven just after the
// rising edge and outputs are compared on the falling edge.
module tb_sal_cmd_scheduler;
  import sal_sched_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   bk_req_valid;
  logic [23:0]  bk_req_cmd;
  logic [111:0] bk_req_addr;
  logic [7:0]   bk_grant;
  logic         ref_req;
  logic         ref_ack;
  logic         cmd_valid;
  logic [2:0]   cmd;
  logic [2:0]   cmd_ba;
  logic [13:0]  cmd_addr;

  sal_cmd_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .bk_req_valid (bk_req_valid),
    .bk_req_cmd   (bk_req_cmd),
    .bk_req_addr  (bk_req_addr),
    .bk_grant     (bk_grant),
    .ref_req      (ref_req),
    .ref_ack      (ref_ack),
    .cmd_valid    (cmd_valid),
    .cmd          (cmd),
    .cmd_ba       (cmd_ba),
    .cmd_addr     (cmd_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst_v;
    logic        ref_v;
    logic [7:0]  valid;
    logic [23:0] cmds;
    logic [7:0]  exp_grant;
    logic        exp_cv;
    logic [2:0]  exp_cmd;
    logic [2:0]  exp_ba;
    logic [13:0] exp_addr;
    logic        exp_ack;
    int          chk;   // 0: skip ba/addr, 1: issued command, 2: reset values
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic logic [23:0] all_c(input logic [2:0] c);
    return {8{c}};
  endfunction

  function automatic logic [23:0] put(input logic [23:0] base, input int bk, input logic [2:0] c);
    logic [23:0] r;
    r = base;
    r[3*bk +: 3] = c;
    return r;
  endfunction

  function automatic logic [13:0] bank_addr(input int bk);
    return 14'(256 + 3 * bk);
  endfunction

  function automatic void add(input string nm, input logic r, input logic rq,
                              input logic [7:0] val, input logic [23:0] cm,
                              input logic [7:0] g, input logic cv, input logic [2:0] c,
                              input int ba, input logic ack, input int chk);
    vec_t v;
    v.name = nm;  v.rst_v = r;  v.ref_v = rq;  v.valid = val;  v.cmds = cm;
    v.exp_grant = g;  v.exp_cv = cv;  v.exp_cmd = c;  v.exp_ba = 3'(ba);
    v.exp_addr = (chk == 2) ? 14'd0 : bank_addr(ba);
    v.exp_ack = ack;  v.chk = chk;
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [23:0] pre8;
    pre8 = all_c(PRE);

    rst          = 1'b1;
    ref_req      = 1'b0;
    bk_req_valid = '0;
    bk_req_cmd   = pre8;
    for (int i = 0; i < 8; i++) bk_req_addr[14*i +: 14] = bank_addr(i);

    // Reset state, then all banks issue PRE: grants rotate 0..7,0.
    add("reset", 1, 0, 8'hFF, pre8, 8'h00, 0, NOP, 0, 0, 2);
    for (int k = 1; k <= 9; k++)
      add($sformatf("rr%0d", k), 0, 0, 8'hFF, pre8, 8'(1 << ((k - 1) % 8)),
          k >= 2, (k >= 2) ? PRE : NOP, (k >= 2) ? k - 2 : 0, 0, (k >= 2) ? 1 : 0);
    add("rr_tail",  0, 0, 8'h00, pre8, 8'h00, 1, PRE, 0, 0, 1);
    add("rr_idle",  0, 0, 8'h00, pre8, 8'h00, 0, NOP, 0, 0, 0);
    // tRRD: bank 2 ACT, bank 5 ACT blocked one cycle, bank 6 PRE slips in.
    add("rrd_t0",   0, 0, 8'h24, put(put(pre8, 2, ACT), 5, ACT), 8'h04, 0, NOP, 0, 0, 0);
    add("rrd_t1",   0, 0, 8'h60, put(pre8, 5, ACT), 8'h40, 1, ACT, 2, 0, 1);
    add("rrd_t2",   0, 0, 8'h20, put(pre8, 5, ACT), 8'h20, 1, PRE, 6, 0, 1);
    add("rrd_t3",   0, 0, 8'h00, pre8, 8'h00, 1, ACT, 5, 0, 1);
    add("rrd_t4",   0, 0, 8'h00, pre8, 8'h00, 0, NOP, 0, 0, 0);
    // tWTR: bank 1 WR then bank 3 RD at t+3.
    add("wtr_t0",   0, 0, 8'h0A, put(put(pre8, 1, WR), 3, RD), 8'h02, 0, NOP, 0, 0, 0);
    add("wtr_t1",   0, 0, 8'h08, put(pre8, 3, RD), 8'h00, 1, WR, 1, 0, 1);
    add("wtr_t2",   0, 0, 8'h08, put(pre8, 3, RD), 8'h00, 0, NOP, 0, 0, 0);
    add("wtr_t3",   0, 0, 8'h08, put(pre8, 3, RD), 8'h08, 0, NOP, 0, 0, 0);
    add("wtr_t4",   0, 0, 8'h00, pre8, 8'h00, 1, RD, 3, 0, 1);
    add("wtr_t5",   0, 0, 8'h00, pre8, 8'h00, 0, NOP, 0, 0, 0);
    add("wtr_t6",   0, 0, 8'h00, pre8, 8'h00, 0, NOP, 0, 0, 0);
    // tCCD: bank 1 WR then bank 3 WR at t+2.
    add("ccdw_t0",  0, 0, 8'h0A, put(put(pre8, 1, WR), 3, WR), 8'h02, 0, NOP, 0, 0, 0);
    add("ccdw_t1",  0, 0, 8'h08, put(pre8, 3, WR), 8'h00, 1, WR, 1, 0, 1);
    add("ccdw_t2",  0, 0, 8'h08, put(pre8, 3, WR), 8'h08, 0, NOP, 0, 0, 0);
    add("ccdw_t3",  0, 0, 8'h00, pre8, 8'h00, 1, WR, 3, 0, 1);
    add("ccdw_t4",  0, 0, 8'h00, pre8, 8'h00, 0, NOP, 0, 0, 0);
    // tRTW: bank 0 RD then bank 4 WR at t+4.
    add("rtw_t0",   0, 0, 8'h01, put(pre8, 0, RD), 8'h01, 0, NOP, 0, 0, 0);
    add("rtw_t1",   0, 0, 8'h10, put(pre8, 4, WR), 8'h00, 1, RD, 0, 0, 1);
    add("rtw_t2",   0, 0, 8'h10, put(pre8, 4, WR), 8'h00, 0, NOP, 0, 0, 0);
    add("rtw_t3",   0, 0, 8'h10, put(pre8, 4, WR), 8'h00, 0, NOP, 0, 0, 0);
    add("rtw_t4",   0, 0, 8'h10, put(pre8, 4, WR), 8'h10, 0, NOP, 0, 0, 0);
    add("rtw_t5",   0, 0, 8'h00, pre8, 8'h00, 1, WR, 4, 0, 1);
    add("rtw_t6",   0, 0, 8'h00, pre8, 8'h00, 0, NOP, 0, 0, 0);
    // tCCD: bank 0 RD then bank 4 RD at t+2.
    add("ccdr_t0",  0, 0, 8'h11, put(put(pre8, 0, RD), 4, RD), 8'h01, 0, NOP, 0, 0, 0);
    add("ccdr_t1",  0, 0, 8'h10, put(pre8, 4, RD), 8'h00, 1, RD, 0, 0, 1);
    add("ccdr_t2",  0, 0, 8'h10, put(pre8, 4, RD), 8'h10, 0, NOP, 0, 0, 0);
    add("ccdr_t3",  0, 0, 8'h00, pre8, 8'h00, 1, RD, 4, 0, 1);
    add("ccdr_t4",  0, 0, 8'h00, pre8, 8'h00, 0, NOP, 0, 0, 0);
    add("ccdr_t5",  0, 0, 8'h00, pre8, 8'h00, 0, NOP, 0, 0, 0);
    add("ccdr_t6",  0, 0, 8'h00, pre8, 8'h00, 0, NOP, 0, 0, 0);
    // Refresh: WR grant, ref_req raised next cycle with requests present.
    add("ref_t0",   0, 0, 8'h40, put(pre8, 6, WR), 8'h40, 0, NOP, 0, 0, 0);
    add("ref_t1",   0, 1, 8'hC0, put(pre8, 6, WR), 8'h00, 1, WR, 6, 0, 1);
    add("ref_t2",   0, 1, 8'hC0, put(pre8, 6, WR), 8'h00, 0, NOP, 0, 0, 0);
    add("ref_t3",   0, 1, 8'hC0, put(pre8, 6, WR), 8'h00, 0, NOP, 0, 1, 0);
    add("ref_t4",   0, 0, 8'hC0, put(pre8, 6, WR), 8'h80, 0, NOP, 0, 1, 0);
    add("ref_t5",   0, 0, 8'h40, put(pre8, 6, WR), 8'h40, 1, PRE, 7, 0, 1);
    add("ref_t6",   0, 0, 8'h00, pre8, 8'h00, 1, WR, 6, 0, 1);
    add("ref_t7",   0, 0, 8'h00, pre8, 8'h00, 0, NOP, 0, 0, 0);
    // Reset mid-operation with rtw/col running and requests pending.
    add("mrst_t0",  0, 0, 8'h04, put(pre8, 2, RD), 8'h04, 0, NOP, 0, 0, 0);
    add("mrst_t1",  1, 0, 8'h26, put(put(put(pre8, 1, WR), 2, RD), 5, RD), 8'h00, 1, RD, 2, 0, 1);
    add("mrst_t2",  0, 0, 8'h22, put(put(pre8, 1, WR), 5, RD), 8'h02, 0, NOP, 0, 0, 2);
    add("mrst_t3",  0, 0, 8'h00, pre8, 8'h00, 1, WR, 1, 0, 1);

    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      rst          = vecs[i].rst_v;
      ref_req      = vecs[i].ref_v;
      bk_req_valid = vecs[i].valid;
      bk_req_cmd   = vecs[i].cmds;
      @(negedge clk);
      check({vecs[i].name, ".grant"},     32'(bk_grant),  32'(vecs[i].exp_grant));
      check({vecs[i].name, ".cmd_valid"}, 32'(cmd_valid), 32'(vecs[i].exp_cv));
      check({vecs[i].name, ".cmd"},       32'(cmd),       32'(vecs[i].exp_cmd));
      check({vecs[i].name, ".ref_ack"},   32'(ref_ack),   32'(vecs[i].exp_ack));
      if (vecs[i].chk != 0) begin
        check({vecs[i].name, ".cmd_ba"},   32'(cmd_ba),   32'(vecs[i].exp_ba));
        check({vecs[i].name, ".cmd_addr"}, 32'(cmd_addr), 32'(vecs[i].exp_addr));
      end
      n_vec++;
      @(posedge clk);
      #1;
    end

    // Raising rst mid-cycle must kill a pending grant combinationally, and the
    // following edge must not issue it.
    rst          = 1'b0;
    ref_req      = 1'b0;
    bk_req_valid = 8'h08;
    bk_req_cmd   = pre8;
    @(negedge clk);
    check("hold_rst.grant_before", 32'(bk_grant), 32'h08);
    rst = 1'b1;
    #1;
    check("hold_rst.grant_forced", 32'(bk_grant), 32'h00);
    n_vec++;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bk_req_valid = 8'h00;
    @(negedge clk);
    check("hold_rst.cmd_valid", 32'(cmd_valid), 32'h0);
    check("hold_rst.cmd",       32'(cmd),       32'(NOP));
    check("hold_rst.cmd_ba",    32'(cmd_ba),    32'h0);
    check("hold_rst.cmd_addr",  32'(cmd_addr),  32'h0);
    n_vec++;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
